std_div_pipe: RTL and testbench

- Multi-cycle iterative integer divider for the core primitive library; successor to the single-cycle std_add/std_sub arithmetic family.
- Restoring division, one quotient bit per cycle, parametrised width, optional signed mode.
- Uses the go/done handshake the compiler emits for multi-cycle primitives.
- Placed wherever a component needs division; the compiler schedules it like std_reg, waiting on done.

---
 rtl/std_div_pkg.sv | 10 +
 rtl/std_div_pipe.sv | 117 +++++++++++
 tb/tb_std_div_pipe.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/std_div_pkg.sv
// Shared types for the iterative restoring divider.
package std_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } div_state_t;

endpackage

// File: rtl/std_div_pipe.sv
// Multi-cycle restoring divider: one quotient bit per clock, optional
// two's-complement mode with truncation toward zero.
module std_div_pipe
  import std_div_pkg::*;
#(
  parameter int width       = 32,
  parameter bit signed_mode = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             go,
  input  logic [width-1:0] left,
  input  logic [width-1:0] right,
  output logic [width-1:0] out_quotient,
  output logic [width-1:0] out_remainder,
  output logic             done,
  output div_state_t       dbg_state
);

  // Handshake: go is sampled only while IDLE, together with left/right;
  // done is high for exactly one cycle (the DONE state) right after the
  // outputs were loaded. go outside IDLE is dropped, never queued.

  localparam int CW = $clog2(width) + 1;

  div_state_t       state_q, state_d;
  logic [CW-1:0]    cnt_q;
  logic [width-1:0] rem_q, dvd_q, dvs_q;
  logic             neg_quo_q, neg_rem_q;

  logic             left_neg, right_neg;
  logic [width-1:0] left_mag, right_mag;
  logic [width:0]   rem_shift, rem_diff;
  logic             q_bit, last_step;
  logic [width-1:0] rem_step, dvd_step, quo_final, rem_final;

  // Magnitudes use plain width-bit negation, so |MIN| stays MIN and is
  // then read as the correct unsigned magnitude.
  always_comb begin
    left_neg  = signed_mode && left[width-1];
    right_neg = signed_mode && right[width-1];
    left_mag  = left_neg  ? -left  : left;
    right_mag = right_neg ? -right : right;
  end

  // One restoring step; the dividend register fills with quotient bits.
  always_comb begin
    rem_shift = {rem_q, dvd_q[width-1]};
    rem_diff  = rem_shift - {1'b0, dvs_q};
    q_bit     = (rem_shift >= {1'b0, dvs_q});
    rem_step  = q_bit ? rem_diff[width-1:0] : rem_shift[width-1:0];
    dvd_step  = {dvd_q[width-2:0], q_bit};
    quo_final = neg_quo_q ? -dvd_step : dvd_step;
    rem_final = neg_rem_q ? -rem_step : rem_step;
    last_step = (cnt_q == CW'(width - 1));
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (go) state_d = (right == '0) ? DONE : BUSY;
      BUSY:    if (last_step) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q         <= '0;
      rem_q         <= '0;
      dvd_q         <= '0;
      dvs_q         <= '0;
      neg_quo_q     <= 1'b0;
      neg_rem_q     <= 1'b0;
      out_quotient  <= '0;
      out_remainder <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (go) begin
            if (right == '0) begin
              out_quotient  <= '1;
              out_remainder <= left;
            end else begin
              dvd_q     <= left_mag;
              dvs_q     <= right_mag;
              rem_q     <= '0;
              cnt_q     <= '0;
              neg_quo_q <= left_neg ^ right_neg;
              neg_rem_q <= left_neg;
            end
          end
        end
        BUSY: begin
          rem_q <= rem_step;
          dvd_q <= dvd_step;
          cnt_q <= cnt_q + 1'b1;
          if (last_step) begin
            out_quotient  <= quo_final;
            out_remainder <= rem_final;
          end
        end
        default: ;
      endcase
    end
  end

  assign done      = (state_q == DONE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_std_div_pipe.sv
// Directed and randomised checks of std_div_pipe at width 8 and 32,
// unsigned and signed.
module tb_std_div_pipe;
  import std_div_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic       go8 = 1'b0;
  logic [7:0] l8 = '0, r8 = '0;
  logic [7:0] u8_q, u8_r, s8_q, s8_r;
  logic       u8_done, s8_done;
  div_state_t u8_state, s8_state;

  logic        go32 = 1'b0;
  logic [31:0] l32 = '0, r32 = '0;
  logic [31:0] u32_q, u32_r, s32_q, s32_r;
  logic        u32_done, s32_done;
  div_state_t  u32_state, s32_state;

  int checks = 0;
  int failures = 0;

  std_div_pipe #(.width(8), .signed_mode(1'b0)) u8 (
    .clk(clk), .reset(reset), .go(go8), .left(l8), .right(r8),
    .out_quotient(u8_q), .out_remainder(u8_r), .done(u8_done), .dbg_state(u8_state));
  std_div_pipe #(.width(8), .signed_mode(1'b1)) s8 (
    .clk(clk), .reset(reset), .go(go8), .left(l8), .right(r8),
    .out_quotient(s8_q), .out_remainder(s8_r), .done(s8_done), .dbg_state(s8_state));
  std_div_pipe #(.width(32), .signed_mode(1'b0)) u32 (
    .clk(clk), .reset(reset), .go(go32), .left(l32), .right(r32),
    .out_quotient(u32_q), .out_remainder(u32_r), .done(u32_done), .dbg_state(u32_state));
  std_div_pipe #(.width(32), .signed_mode(1'b1)) s32 (
    .clk(clk), .reset(reset), .go(go32), .left(l32), .right(r32),
    .out_quotient(s32_q), .out_remainder(s32_r), .done(s32_done), .dbg_state(s32_state));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Accept one 8-bit operation and return at the negedge where done is seen.
  // lat counts edges after the accept edge before done became visible.
  task automatic op8(input logic [7:0] a, input logic [7:0] b, input int exp_lat,
                     input string tag);
    int lat;
    @(negedge clk); go8 = 1'b1; l8 = a; r8 = b;
    @(negedge clk); go8 = 1'b0;
    lat = 0;
    while (!u8_done && lat < 40) begin
      @(negedge clk); lat++;
    end
    chk({tag, "_lat"}, lat, exp_lat);
    chk({tag, "_sdone"}, 32'(s8_done), 32'd1);
  endtask

  task automatic op32(input logic [31:0] a, input logic [31:0] b);
    int lat;
    logic [31:0] eu_q, eu_r, es_q, es_r;
    int sa, sb;
    sa = a; sb = b;
    if (b == 32'd0) begin
      eu_q = '1; eu_r = a; es_q = '1; es_r = a;
    end else begin
      eu_q = a / b; eu_r = a % b;
      if (b == 32'hFFFF_FFFF) begin
        es_q = -a; es_r = 32'd0;
      end else begin
        es_q = 32'(sa / sb); es_r = 32'(sa % sb);
      end
    end
    @(negedge clk); go32 = 1'b1; l32 = a; r32 = b;
    @(negedge clk); go32 = 1'b0; l32 = $urandom(); r32 = $urandom();
    lat = 0;
    while (!u32_done && lat < 60) begin
      @(negedge clk); lat++;
    end
    chk("r32_lat", lat, (b == 32'd0) ? 0 : 32);
    chk("r32_sdone", 32'(s32_done), 32'd1);
    chk("r32_uq", u32_q, eu_q);
    chk("r32_ur", u32_r, eu_r);
    chk("r32_sq", s32_q, es_q);
    chk("r32_sr", s32_r, es_r);
  endtask

  initial begin
    int done_cnt, first_at, prev_at, saw_done;
    logic [31:0] ra, rb;
    int sel;

    repeat (3) @(posedge clk);
    @(negedge clk); reset = 1'b0;
    chk("rst_state", 32'(u8_state), 32'(IDLE));
    chk("rst_done", 32'(u8_done), 32'd0);
    chk("rst_q", 32'(u8_q), 32'd0);
    chk("rst_r", 32'(u8_r), 32'd0);
    chk("rst_s32_q", s32_q, 32'd0);

    // 200 / 7 = 28 r 4, done visible after 8 edges
    op8(8'd200, 8'd7, 8, "u200_7");
    chk("u200_7_q", 32'(u8_q), 32'd28);
    chk("u200_7_r", 32'(u8_r), 32'd4);
    @(negedge clk);
    chk("u200_7_pulse", 32'(u8_done), 32'd0);
    repeat (3) @(negedge clk);
    chk("u200_7_hold_q", 32'(u8_q), 32'd28);
    chk("u200_7_hold_r", 32'(u8_r), 32'd4);

    // divide by zero: immediate, all-ones quotient, dividend as remainder
    op8(8'd55, 8'd0, 0, "u55_0");
    chk("u55_0_q", 32'(u8_q), 32'hFF);
    chk("u55_0_r", 32'(u8_r), 32'd55);
    chk("s55_0_q", 32'(s8_q), 32'hFF);
    chk("s55_0_r", 32'(s8_r), 32'd55);
    @(negedge clk);
    chk("u55_0_pulse", 32'(u8_done), 32'd0);

    // signed: -7/2 = -3 r -1 ; unsigned view 249/2 = 124 r 1
    op8(8'hF9, 8'h02, 8, "s_m7_2");
    chk("s_m7_2_q", 32'(s8_q), 32'hFD);
    chk("s_m7_2_r", 32'(s8_r), 32'hFF);
    chk("u249_2_q", 32'(u8_q), 32'd124);
    chk("u249_2_r", 32'(u8_r), 32'd1);
    op8(8'h07, 8'hFE, 8, "s_7_m2");
    chk("s_7_m2_q", 32'(s8_q), 32'hFD);
    chk("s_7_m2_r", 32'(s8_r), 32'h01);
    op8(8'h80, 8'hFF, 8, "s_min_m1");
    chk("s_min_m1_q", 32'(s8_q), 32'h80);
    chk("s_min_m1_r", 32'(s8_r), 32'h00);
    op8(8'h85, 8'h00, 0, "s_neg_0");
    chk("s_neg_0_q", 32'(s8_q), 32'hFF);
    chk("s_neg_0_r", 32'(s8_r), 32'h85);

    // go held high: restarts every 10 cycles; left disturbed mid-BUSY
    @(negedge clk); go8 = 1'b1; l8 = 8'd100; r8 = 8'd10;
    done_cnt = 0; first_at = -1; prev_at = -1;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (c == 3) l8 = 8'd77;
      if (c == 6) l8 = 8'd100;
      if (c == 30) go8 = 1'b0;
      if (u8_done) begin
        done_cnt++;
        chk("held_q", 32'(u8_q), 32'd10);
        chk("held_r", 32'(u8_r), 32'd0);
        if (first_at < 0) first_at = c;
        else chk("held_spacing", c - prev_at, 10);
        prev_at = c;
      end
    end
    chk("held_count", done_cnt, 3);
    chk("held_first", first_at, 9);
    repeat (3) @(negedge clk);
    chk("held_idle", 32'(u8_state), 32'(IDLE));

    // reset 3 cycles into BUSY aborts the operation and zeroes outputs
    @(negedge clk); go8 = 1'b1; l8 = 8'd200; r8 = 8'd7;
    saw_done = 0;
    @(negedge clk); go8 = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if (u8_done) saw_done++;
    end
    chk("abort_busy", 32'(u8_state), 32'(BUSY));
    reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    chk("abort_q", 32'(u8_q), 32'd0);
    chk("abort_r", 32'(u8_r), 32'd0);
    chk("abort_state", 32'(u8_state), 32'(IDLE));
    repeat (12) begin
      @(negedge clk);
      if (u8_done) saw_done++;
    end
    chk("abort_no_done", saw_done, 0);
    op8(8'd9, 8'd4, 8, "u9_4");
    chk("u9_4_q", 32'(u8_q), 32'd2);
    chk("u9_4_r", 32'(u8_r), 32'd1);

    // 32-bit regression against a language-level reference
    for (int n = 0; n < 1000; n++) begin
      sel = $urandom_range(0, 9);
      case (sel)
        0:       rb = 32'd0;
        1:       rb = 32'd1;
        2:       rb = 32'hFFFF_FFFF;
        3, 4:    rb = $urandom_range(1, 1000);
        5:       rb = -$urandom_range(1, 1000);
        default: rb = $urandom();
      endcase
      sel = $urandom_range(0, 9);
      case (sel)
        0:       ra = 32'd0;
        1:       ra = 32'h8000_0000;
        2:       ra = $urandom_range(0, 1000);
        3:       ra = -$urandom_range(0, 1000);
        default: ra = $urandom();
      endcase
      op32(ra, rb);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
